// File: rtl/router_pkg.sv
// Shared types and flit-field helpers for the router datapath stages.
package router_pkg;

  localparam int FLIT_W   = 11;
  localparam int HOP_W    = 4;
  localparam int TAIL_BIT = FLIT_W - 1;
  localparam int HOP_MSB  = FLIT_W - 2;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    S_HEAD,
    S_CONT,
    S_LOCAL
  } rt_state_t;

  // Hop-count field of a head flit.
  function automatic logic [HOP_W-1:0] hop_of(input flit_t f);
    return f[HOP_MSB -: HOP_W];
  endfunction

  // Head flit with its hop count decremented; all other bits untouched.
  // Callers only use this on hop != 0, so the field never wraps.
  function automatic flit_t dec_hop(input flit_t f);
    flit_t r;
    r = f;
    r[HOP_MSB -: HOP_W] = f[HOP_MSB -: HOP_W] - HOP_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/router_input_unit_flit_reg.sv
// One-entry pipeline register in front of a first-word-fall-through FIFO.
// Pops whenever the slot is empty or is being drained this cycle, so a
// steady stream moves at one flit per clock with no bubbles.
module flit_reg
  import router_pkg::*;
#(
  parameter int W = FLIT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_empty,
  input  logic [W-1:0] in_data,
  input  logic         xfer,
  output logic         in_rd,
  output logic         flit_v,
  output logic [W-1:0] flit_q
);

  // Pop when data is available and the slot is free or emptying; never
  // pop while reset is held, since the popped flit would be thrown away.
  always_comb begin
    in_rd = reset_n & ~in_empty & (~flit_v | xfer);
  end

  // Valid flag: refill has priority over drain so a same-cycle
  // pop and transfer keeps the slot full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flit_v <= 1'b0;
    end else if (in_rd) begin
      flit_v <= 1'b1;
    end else if (xfer) begin
      flit_v <= 1'b0;
    end
  end

  // Flit payload: loaded on every pop, only meaningful while flit_v is set.
  always_ff @(posedge clk) begin
    if (in_rd) begin
      flit_q <= in_data;
    end
  end

endmodule

// File: rtl/router_input_unit.sv
// Router input stage: routes each packet either onward (hop decremented in
// the head) or to the local Braindrop output, holding the chosen output
// for the whole packet and counting delivered packets per output.
module router_input_unit
  import router_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_empty,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_rd,
  output logic              req_cont,
  output logic [FLIT_W-1:0] data_cont,
  input  logic              ready_cont,
  output logic              req_local,
  output logic [FLIT_W-1:0] data_local,
  input  logic              ready_local,
  output logic [CNT_W-1:0]  pkt_cont_cnt,
  output logic [CNT_W-1:0]  pkt_local_cnt
);

  rt_state_t        state_q;
  rt_state_t        state_d;
  logic             flit_v;
  flit_t            flit_q;
  logic             xfer;
  logic             inc_cont;
  logic             inc_local;
  logic [HOP_W-1:0] hop;
  logic             tail;

  flit_reg #(
    .W(FLIT_W)
  ) u_flit_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .in_empty(in_empty),
    .in_data (in_data),
    .xfer    (xfer),
    .in_rd   (in_rd),
    .flit_v  (flit_v),
    .flit_q  (flit_q)
  );

  // Route decode, request/data generation and next-state logic. Idle data
  // outputs are held at zero so no allocator ever sees a stray tail bit.
  always_comb begin
    req_cont   = 1'b0;
    req_local  = 1'b0;
    data_cont  = '0;
    data_local = '0;
    state_d    = state_q;
    inc_cont   = 1'b0;
    inc_local  = 1'b0;
    xfer       = 1'b0;
    hop        = hop_of(flit_q);
    tail       = flit_q[TAIL_BIT];

    if (flit_v) begin
      case (state_q)
        S_HEAD: begin
          if (hop == '0) begin
            req_local  = 1'b1;
            data_local = flit_q;
          end else begin
            req_cont  = 1'b1;
            data_cont = dec_hop(flit_q);
          end
        end
        S_CONT: begin
          req_cont  = 1'b1;
          data_cont = flit_q;
        end
        S_LOCAL: begin
          req_local  = 1'b1;
          data_local = flit_q;
        end
        default: ;
      endcase

      // Only the selected output's ready matters; the other is ignored.
      xfer = (req_cont & ready_cont) | (req_local & ready_local);

      if (xfer) begin
        if (tail) begin
          inc_cont  = req_cont;
          inc_local = req_local;
          state_d   = S_HEAD;
        end else if (state_q == S_HEAD) begin
          state_d = req_local ? S_LOCAL : S_CONT;
        end
      end
    end
  end

  // Route state register; reset abandons any packet in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Delivered-packet counters, bumped when a tail leaves; they wrap freely.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_cont_cnt  <= '0;
      pkt_local_cnt <= '0;
    end else begin
      if (inc_cont) begin
        pkt_cont_cnt <= pkt_cont_cnt + CNT_W'(1);
      end
      if (inc_local) begin
        pkt_local_cnt <= pkt_local_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Scoreboard bench for router_input_unit: a FWFT FIFO model feeds flits,
// expected output flits are queued at issue time and a negedge monitor
// checks every transfer, request exclusivity, idle-zero data and stability.
module tb_router_input_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_empty;
  logic [10:0] in_data;
  logic        in_rd;
  logic        req_cont;
  logic [10:0] data_cont;
  logic        ready_cont;
  logic        req_local;
  logic [10:0] data_local;
  logic        ready_local;
  logic [3:0]  pkt_cont_cnt;
  logic [3:0]  pkt_local_cnt;

  always #5 clk = ~clk;

  router_input_unit #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_empty     (in_empty),
    .in_data      (in_data),
    .in_rd        (in_rd),
    .req_cont     (req_cont),
    .data_cont    (data_cont),
    .ready_cont   (ready_cont),
    .req_local    (req_local),
    .data_local   (data_local),
    .ready_local  (ready_local),
    .pkt_cont_cnt (pkt_cont_cnt),
    .pkt_local_cnt(pkt_local_cnt)
  );

  typedef struct packed {
    logic        port;  // 1 = local, 0 = continue
    logic [10:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] fifo[$];
  int          xc[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    in_empty = (fifo.size() == 0);
    in_data  = (fifo.size() != 0) ? fifo[0] : 11'h0;
  endtask

  task automatic push_flit(input logic [10:0] f, input logic port, input logic [10:0] ed);
    exp_t e;
    e.port = port;
    e.data = ed;
    fifo.push_back(f);
    exp_q.push_back(e);
    refresh();
  endtask

  // Packet layout: [10] tail, [9:6] hop (head only), [5:0] payload.
  task automatic send_pkt(input logic [3:0] hop, input int len, input logic [5:0] pay);
    logic [10:0] f;
    logic [10:0] ed;
    logic        port;
    port = (hop == 4'd0);
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        f  = {(len == 1), hop, pay};
        ed = port ? f : {(len == 1), hop - 4'd1, pay};
      end else begin
        f  = {(i == len - 1), 4'(i + 7), pay ^ 6'(i)};
        ed = f;
      end
      push_flit(f, port, ed);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && fifo.size() == 0 && !req_cont && !req_local) break;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s drain timeout: %0d flits still expected", name, exp_q.size());
    end
  endtask

  // FIFO model: pop the flit the DUT read at the previous edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_seen) begin
      if (fifo.size() != 0) fifo.delete(0);
      rd_seen = 1'b0;
    end
    refresh();
  end

  logic        pv_c = 1'b0, pv_l = 1'b0;
  logic        px_c = 1'b0, px_l = 1'b0;
  logic [10:0] pd_c, pd_l;

  // Monitor: scoreboard compare on each transfer plus protocol checks.
  always @(negedge clk) begin
    logic xf_c, xf_l;
    exp_t e;
    rd_seen = in_rd;
    xf_c = req_cont & ready_cont;
    xf_l = req_local & ready_local;
    if (req_cont || req_local) check("req_exclusive", {req_cont, req_local} != 2'b11, 1);
    if (!req_cont) check("idle_data_cont", data_cont, 0);
    if (!req_local) check("idle_data_local", data_local, 0);
    if (pv_c && !px_c) begin
      check("hold_req_cont", req_cont, 1);
      check("hold_data_cont", data_cont, pd_c);
    end
    if (pv_l && !px_l) begin
      check("hold_req_local", req_local, 1);
      check("hold_data_local", data_local, pd_l);
    end
    if (xf_c || xf_l) begin
      xc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got port %0d data 0x%0h, none expected", xf_l, xf_l ? data_local : data_cont);
      end else begin
        e = exp_q.pop_front();
        check("xfer_port", xf_l, e.port);
        check("xfer_data", xf_l ? data_local : data_cont, e.data);
      end
    end
    pv_c = reset_n & req_cont;
    pv_l = reset_n & req_local;
    px_c = xf_c;
    px_l = xf_l;
    pd_c = data_cont;
    pd_l = data_local;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    ready_cont  = 1'b0;
    ready_local = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_rd", in_rd, 0);
    check("rst_req_cont", req_cont, 0);
    check("rst_req_local", req_local, 0);
    check("rst_data_cont", data_cont, 0);
    check("rst_data_local", data_local, 0);
    check("rst_cnt_cont", pkt_cont_cnt, 0);
    check("rst_cnt_local", pkt_local_cnt, 0);
    reset_n     = 1'b1;
    ready_cont  = 1'b1;
    ready_local = 1'b1;

    // Single-flit local packet, one cycle from pop to request.
    @(posedge clk);
    #2;
    send_pkt(4'd0, 1, 6'h15);
    @(negedge clk);
    check("t1_in_rd", in_rd, 1);
    check("t1_req_early", req_local, 0);
    @(negedge clk);
    check("t1_req_local", req_local, 1);
    check("t1_data_local", data_local, 11'h415);
    check("t1_req_cont", req_cont, 0);
    wait_drain("t1");
    check("t1_cnt_local", pkt_local_cnt, 1);
    check("t1_cnt_cont", pkt_cont_cnt, 0);

    // Three-flit continue packet, hop 3 -> 2, no bubbles.
    send_pkt(4'd3, 3, 6'h2A);
    wait_drain("t2");
    check("t2_no_bubble", xc[xc.size()-1] - xc[xc.size()-3], 2);
    check("t2_cnt_cont", pkt_cont_cnt, 1);

    // Backpressure for five cycles mid-packet.
    send_pkt(4'd5, 4, 6'h33);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() <= 2) break;
    end
    ready_cont = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t3_stall_req", req_cont, 1);
      check("t3_stall_in_rd", in_rd, 0);
      check("t3_stall_fifo", in_empty, 0);
    end
    @(posedge clk);
    #2;
    ready_cont = 1'b1;
    wait_drain("t3");
    check("t3_cnt_cont", pkt_cont_cnt, 2);

    // Back-to-back: continue packet then local packet, no gap between them.
    send_pkt(4'd1, 3, 6'h01);
    send_pkt(4'd0, 2, 6'h3C);
    wait_drain("t4");
    check("t4_back_to_back", xc[xc.size()-1] - xc[xc.size()-5], 4);
    check("t4_cnt_cont", pkt_cont_cnt, 3);
    check("t4_cnt_local", pkt_local_cnt, 2);

    // Reset right after a head transfers; next head routes from scratch.
    push_flit({1'b0, 4'd2, 6'h11}, 1'b0, {1'b0, 4'd1, 6'h11});
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    reset_n = 1'b0;
    fifo.push_back({1'b1, 4'd9, 6'h22});
    refresh();
    @(negedge clk);
    check("t5_rd_in_reset", in_rd, 0);
    @(posedge clk);
    #2;
    check("t5_req_cont", req_cont, 0);
    check("t5_req_local", req_local, 0);
    check("t5_in_rd", in_rd, 0);
    check("t5_cnt_cont", pkt_cont_cnt, 0);
    check("t5_cnt_local", pkt_local_cnt, 0);
    fifo.delete();
    exp_q.delete();
    refresh();
    reset_n = 1'b1;
    send_pkt(4'd0, 1, 6'h05);
    wait_drain("t5");
    check("t5_fresh_local", pkt_local_cnt, 1);
    check("t5_fresh_cont", pkt_cont_cnt, 0);

    // Counter wrap: 17 more local packets on a 4-bit counter.
    for (int i = 0; i < 17; i++) send_pkt(4'd0, 1, 6'(i));
    wait_drain("t6");
    check("t6_wrap_local", pkt_local_cnt, 2);
    check("t6_wrap_cont", pkt_cont_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
